// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble of 1s, a 0 separator, then the payload MSB-first with
// a 0 stuffed after every STUFF_RUN consecutive payload 1s.
module serial_frame_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PRE_LEN   = 3,
  parameter int unsigned STUFF_RUN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned IW = $clog2(DATA_W) + 1;
  localparam int unsigned PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam int unsigned RW = $clog2(STUFF_RUN + 1);

  typedef enum logic [2:0] {StIdle, StPre, StSep, StData, StStuff} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [IW-1:0]     idx_q;
  logic [PW-1:0]     pre_cnt_q;
  logic [RW-1:0]     run_q;

  logic          cur_bit;
  logic [RW-1:0] run_inc;
  logic          stuff_now;
  logic          last_bit;

  // Payload is shifted out of the top bit; idx_q tracks which payload bit is current.
  assign cur_bit   = data_q[DATA_W-1];
  assign run_inc   = cur_bit ? run_q + RW'(1) : '0;
  assign stuff_now = (run_inc == RW'(STUFF_RUN));
  assign last_bit  = (idx_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      idx_q     <= '0;
      pre_cnt_q <= '0;
      run_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q    <= in_data;
            idx_q     <= '0;
            run_q     <= '0;
            pre_cnt_q <= '0;
            state_q   <= StPre;
          end
        end
        StPre: begin
          if (pre_cnt_q == PW'(PRE_LEN - 1)) begin
            pre_cnt_q <= '0;
            state_q   <= StSep;
          end else begin
            pre_cnt_q <= pre_cnt_q + PW'(1);
          end
        end
        StSep: begin
          idx_q   <= IW'(DATA_W - 1);
          state_q <= StData;
        end
        StData: begin
          data_q <= data_q << 1;
          run_q  <= run_inc;
          if (stuff_now) begin
            state_q <= StStuff;
          end else if (last_bit) begin
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        StStuff: begin
          run_q <= '0;
          if (last_bit) begin
            state_q <= StIdle;
          end else begin
            idx_q   <= idx_q - IW'(1);
            state_q <= StData;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced low for the whole cycle that rst is held.
  assign in_ready   = !rst && (state_q == StIdle);
  assign busy       = !rst && (state_q != StIdle);
  assign out        = !rst && ((state_q == StPre) || ((state_q == StData) && cur_bit));
  assign frame_done = !rst && (((state_q == StData) && last_bit && !stuff_now) ||
                               ((state_q == StStuff) && last_bit));

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed frames, back-to-back, mid-frame reset and random words,
// each compared bit-by-bit against a queue-based frame model.
module tb_serial_frame_tx;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PRE_LEN   = 3;
  localparam int unsigned STUFF_RUN = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_started = 0;
  int det_fires = 0;
  int ones_run = 0;

  serial_frame_tx #(
    .DATA_W   (DATA_W),
    .PRE_LEN  (PRE_LEN),
    .STUFF_RUN(STUFF_RUN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out       (out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Downstream "PRE_LEN ones" detector on the serial line.
  always @(negedge clk) begin
    ones_run <= out ? ones_run + 1 : 0;
    if (out && ones_run == PRE_LEN - 1) det_fires <= det_fires + 1;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected serial line for one frame, built directly from the framing rules.
  function automatic void build_frame(input logic [DATA_W-1:0] word, output bit q[$]);
    int run;
    q = {};
    for (int i = 0; i < PRE_LEN; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    run = 0;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      q.push_back(word[b]);
      run = word[b] ? run + 1 : 0;
      if (run == STUFF_RUN) begin
        q.push_back(1'b0);
        run = 0;
      end
    end
  endfunction

  // Called just after a negedge with the DUT idle; returns just after the negedge of the
  // first idle cycle following the frame.
  task automatic send_frame(input logic [DATA_W-1:0] word, input bit keep_valid,
                            input logic [DATA_W-1:0] next_word);
    bit q[$];
    build_frame(word, q);
    check("idle_ready", in_ready, 1'b1);
    check("idle_out", out, 1'b0);
    check("idle_busy", busy, 1'b0);
    in_valid = 1'b1;
    in_data  = word;
    @(posedge clk);
    #1;
    frames_started++;
    if (keep_valid) in_data = next_word;
    else in_valid = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check($sformatf("out[%0h.%0d]", word, i), out, q[i]);
      check("busy", busy, 1'b1);
      check("ready_low", in_ready, 1'b0);
      check($sformatf("done[%0h.%0d]", word, i), frame_done, logic'(i == q.size() - 1));
    end
    @(negedge clk);
  endtask

  initial begin
    bit q[$];
    logic [DATA_W-1:0] w;
    int gap;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 1'b0);
    check("rst_out", out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    send_frame(8'h00, 1'b0, 8'h00);
    send_frame(8'hFF, 1'b0, 8'h00);
    send_frame(8'hA5, 1'b0, 8'h00);
    send_frame(8'h03, 1'b0, 8'h00);

    // Back-to-back with in_valid held high: one idle cycle between frames.
    send_frame(8'hFF, 1'b1, 8'h81);
    send_frame(8'h81, 1'b0, 8'h00);

    // Abort an 8'hFF frame in its data phase with a one-cycle reset.
    build_frame(8'hFF, q);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    frames_started++;
    for (int i = 0; i < PRE_LEN + 3; i++) begin
      @(negedge clk);
      check("abort_out", out, q[i]);
      check("abort_done", frame_done, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out", out, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_done", frame_done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_out", out, 1'b0);
    check("post_rst_done", frame_done, 1'b0);
    send_frame(8'hFF, 1'b0, 8'h00);

    // Random words with random idle gaps.
    for (int n = 0; n < 30; n++) begin
      w   = DATA_W'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        check("gap_out", out, 1'b0);
        check("gap_ready", in_ready, 1'b1);
        @(negedge clk);
      end
      send_frame(w, 1'b0, 8'h00);
    end

    @(negedge clk);
    n_checks++;
    assert (det_fires === frames_started) else begin
      n_fail++;
      $error("FAIL detector_fires: observed %0d expected %0d", det_fires, frames_started);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Serial transmitter for the single-bit sequence-detect line. Takes parallel words over a valid/ready handshake and emits one frame per word: a run of 1s as preamble, a 0 separator, then the payload MSB-first.
- Zeros are stuffed into the payload so it never contains a run of 1s long enough to look like the preamble. A downstream detector therefore fires only on the preamble.
- Sits upstream of the FSM-based detectors on the same serial wire.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PRE_LEN, 3, number of consecutive 1s in the preamble (>=2).
- STUFF_RUN, 2, a 0 is inserted after every STUFF_RUN consecutive payload 1s; must satisfy 1 <= STUFF_RUN < PRE_LEN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  payload word offered.
- in_data  in  DATA_W  payload word; sampled only on handshake.
- in_ready  out  1  block can accept a word.
- out  out  1  serial line.
- busy  out  1  frame in progress.
- frame_done  out  1  high during the last bit-cycle of a frame.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE, all counters 0, payload register 0. While rst is high: out=0, in_ready=0, busy=0, frame_done=0.
  - Reset mid-frame aborts the frame. out=0 from the cycle after the reset edge. No frame_done is given.
- FSM states: IDLE, PRE, SEP, DATA, STUFF. out is decoded from the registered state (Moore):
  - IDLE and SEP drive 0.
  - PRE drives 1.
  - DATA drives the current payload bit.
  - STUFF drives 0.
- IDLE:
  - in_ready=1, busy=0.
  - Handshake = in_valid && in_ready at a rising edge. On handshake, latch in_data, clear the bit index and the ones-run counter, go to PRE.
  - in_valid with in_ready=0 is ignored. The word must be held by the source.
- PRE: exactly PRE_LEN cycles, then SEP.
- SEP: exactly 1 cycle, then DATA at bit DATA_W-1.
- DATA, each cycle:
  - If the bit sent is 1, the run counter increments; if 0, it clears.
  - If the run reaches STUFF_RUN, the next cycle is STUFF. Otherwise the next cycle is the next lower bit, or IDLE after bit 0.
- STUFF: 1 cycle of 0, run counter cleared. Then the next lower bit, or IDLE if bit 0 was already sent.
  - A stuff bit is inserted after the final payload bit too, if the run completes there.
- frame_done: high in the final DATA or STUFF cycle of the frame, i.e. the cycle before returning to IDLE.
- busy: high in every non-IDLE state.
- in_ready: low in every non-IDLE state. No accept is possible while busy.
- Gap between frames: at least one IDLE cycle (out=0) between consecutive frames. Back-to-back frames therefore recur every PRE_LEN+1+DATA_W+stuffs+1 cycles.
- Frame length:
  - PRE_LEN+1+DATA_W+S cycles, where S is the number of stuff bits.
  - S <= floor(DATA_W/STUFF_RUN).
  - The bit-index counter is sized clog2(DATA_W)+1 and must not wrap.
- Guarantee: with STUFF_RUN < PRE_LEN, the longest run of 1s on out outside the preamble is STUFF_RUN.

Test Plan (default parameters):
1. Reset, then in_data=8'h00 handshake at edge T.
   - out is 1 at T+1..T+3, 0 at T+4, 0 at T+5..T+12.
   - frame_done at T+12; in_ready=1 at T+13.
2. in_data=8'hFF.
   - Data phase is 1,1,0,1,1,0,1,1,0,1,1,0 (12 cycles, 4 stuffs).
   - Frame is 16 cycles; frame_done on the final stuff cycle.
3. in_data=8'hA5 (1010_0101).
   - Data phase is exactly 1,0,1,0,0,1,0,1; no stuffing; 12-cycle frame.
4. in_data=8'h03.
   - Data phase is 0,0,0,0,0,0,1,1,0 (trailing stuff).
   - frame_done on the trailing 0; 13-cycle frame.
5. Hold in_valid=1 continuously with 8'hFF then 8'h81.
   - in_ready is low throughout frame 1 and the second word is not consumed early.
   - Exactly one IDLE cycle separates the frames.
   - The 8'h81 frame is 12 cycles; a detector for "PRE_LEN ones" fires once per frame.
6. Assert rst for 1 cycle during the DATA phase of an 8'hFF frame.
   - out=0, busy=0, in_ready=0 in the rst cycle; no frame_done.
   - in_ready=1 on the cycle after rst drops.
   - The next handshake produces a complete, correct frame.
